pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage CPU (generic MEM/WB, EX/MEM, ID/EX).

---
 rtl/pipe_stage_skid.sv | 61 ++++++
 tb/tb_pipe_stage_skid.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready inter-stage register with flush, optional 2-entry skid buffer and stall counter
module pipe_stage_skid #(
  parameter int CTRL_W   = 3,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 3,
  parameter int REG_W    = 5,
  parameter int MODE     = 1,
  parameter int ZERO_BUB = 1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]           in_dst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]           out_dst,
  output logic [1:0]                 occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);
  localparam int PW = CTRL_W + NUM_DATA*DATA_W + REG_W;
  logic          r_main_v, r_skid_v;
  logic [PW-1:0] r_main, r_skid;
  logic [CNT_W-1:0] r_stall;
  logic          w_acc, w_emit;
  logic [PW-1:0] w_in, w_out;
  assign w_in      = {in_ctrl, in_data, in_dst};
  // skid mode derives ready from state only, so out_ready never reaches in_ready
  assign in_ready  = !rst && (MODE == 1 ? !r_skid_v : (!r_main_v || out_ready));
  assign w_acc     = in_valid && in_ready;
  assign w_emit    = r_main_v && out_ready;
  assign out_valid = r_main_v;
  assign w_out     = (ZERO_BUB != 0 && !r_main_v) ? '0 : r_main;
  assign {out_ctrl, out_data, out_dst} = w_out;
  assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};
  assign stall_cnt = r_stall;
  always_ff @(posedge clk)
    if (rst || flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else if (!r_main_v || w_emit) begin
      r_main_v <= r_skid_v || w_acc;
      r_skid_v <= 1'b0;
      if (r_skid_v) r_main <= r_skid;
      else if (w_acc) r_main <= w_in;
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
      r_skid   <= w_in;
    end
  always_ff @(posedge clk)
    if (rst) r_stall <= '0;
    else if (r_main_v && !out_ready && r_stall != '1) r_stall <= r_stall + 1'b1;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed table, corner sequences and random traffic against a queue model
module tb_pipe_stage_skid;
  localparam int CW = 3, DW = 32, ND = 3, RW = 5, PW = CW + ND*DW + RW;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] tag = 8'h0;
  logic [CW-1:0] in_ctrl;
  logic [ND*DW-1:0] in_data;
  logic [RW-1:0] in_dst;
  logic ov[3], ir[3];
  logic [CW-1:0] oc[3];
  logic [ND*DW-1:0] od[3];
  logic [RW-1:0] odst[3];
  logic [1:0] occ[3];
  logic [15:0] sc0, sc1;
  logic [3:0] sc4;
  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;
  logic [PW-1:0] mq[3][2];
  int mcnt[3], mst[3];
  typedef struct {
    bit r, f, v, o, eov, eir;
    logic [7:0] t, et;
    int eocc, est;
  } vec_t;
  vec_t tbl[30];

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pl(input logic [7:0] t);
    logic [31:0] w;
    w = {24'd0, t};
    return {t[2:0], ~w, w ^ 32'hA5A5_0000, w, t[4:0]};
  endfunction
  assign {in_ctrl, in_data, in_dst} = pl(tag);

  pipe_stage_skid u_m1 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_dst(in_dst), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]), .out_dst(odst[0]), .occupancy(occ[0]), .stall_cnt(sc0));
  pipe_stage_skid #(.MODE(0)) u_m0 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_dst(in_dst), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]), .out_dst(odst[1]), .occupancy(occ[1]), .stall_cnt(sc1));
  pipe_stage_skid #(.CNT_W(4)) u_c4 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_dst(in_dst), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_data(od[2]), .out_dst(odst[2]), .occupancy(occ[2]), .stall_cnt(sc4));

  function automatic int dsc(input int i);
    return i == 0 ? int'(sc0) : i == 1 ? int'(sc1) : int'(sc4);
  endfunction
  function automatic logic [PW-1:0] dpl(input int i);
    return {oc[i], od[i], odst[i]};
  endfunction

  task automatic chk(input string n, input logic [PW-1:0] a, input logic [PW-1:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic bit m_rdy(input int i);
    return !rst && (i == 1 ? (mcnt[i] == 0 || out_ready) : mcnt[i] < 2);
  endfunction

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m%0d_valid", i), PW'(ov[i]), PW'(mcnt[i] > 0));
      chk($sformatf("m%0d_ready", i), PW'(ir[i]), PW'(m_rdy(i)));
      chk($sformatf("m%0d_payload", i), dpl(i), mcnt[i] > 0 ? mq[i][0] : '0);
      chk($sformatf("m%0d_occ", i), PW'(occ[i]), PW'(mcnt[i]));
      chk($sformatf("m%0d_stall", i), PW'(dsc(i)), PW'(mst[i]));
    end
  endtask

  task automatic model_step();
    bit rdy;
    for (int i = 0; i < 3; i++) begin
      rdy = m_rdy(i);
      if (rst) begin
        mcnt[i] = 0;
        mst[i] = 0;
      end else begin
        if (mcnt[i] > 0 && !out_ready && mst[i] < (i == 2 ? 15 : 65535)) mst[i]++;
        if (mcnt[i] > 0 && out_ready) begin
          mq[i][0] = mq[i][1];
          mcnt[i]--;
        end
        if (flush) mcnt[i] = 0;
        else if (in_valid && rdy) begin
          mq[i][mcnt[i]] = pl(tag);
          mcnt[i]++;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit f, input bit v, input logic [7:0] t, input bit o);
    @(posedge clk);
    #1;
    rst = r; flush = f; in_valid = v; tag = t; out_ready = o;
    @(negedge clk);
    if (chk_en) model_check();
    model_step();
  endtask

  function automatic vec_t V(input int r, f, v, t, o, eov, eir, et, eocc, est);
    vec_t x;
    x.r = r[0]; x.f = f[0]; x.v = v[0]; x.t = t[7:0]; x.o = o[0];
    x.eov = eov[0]; x.eir = eir[0]; x.et = et[7:0]; x.eocc = eocc; x.est = est;
    return x;
  endfunction

  initial begin
    tbl[0] = V(0,0,1,8'h01,1, 0,1,8'h00,0,0);
    for (int k = 1; k < 8; k++) tbl[k] = V(0,0,1,k+1,1, 1,1,k,1,0);
    tbl[8]  = V(0,0,0,8'h00,1, 1,1,8'h08,1,0);
    tbl[9]  = V(0,0,0,8'h00,1, 0,1,8'h00,0,0);
    tbl[10] = V(0,0,1,8'h11,0, 0,1,8'h00,0,0);
    tbl[11] = V(0,0,1,8'h22,0, 1,1,8'h11,1,0);
    tbl[12] = V(0,0,0,8'h00,0, 1,0,8'h11,2,1);
    tbl[13] = V(0,0,0,8'h00,0, 1,0,8'h11,2,2);
    tbl[14] = V(0,0,0,8'h00,1, 1,0,8'h11,2,3);
    tbl[15] = V(0,0,0,8'h00,1, 1,1,8'h22,1,3);
    tbl[16] = V(0,0,0,8'h00,1, 0,1,8'h00,0,3);
    tbl[17] = V(0,0,1,8'h44,0, 0,1,8'h00,0,3);
    tbl[18] = V(0,0,1,8'h55,0, 1,1,8'h44,1,3);
    tbl[19] = V(0,1,1,8'h33,0, 1,0,8'h44,2,4);
    tbl[20] = V(0,0,0,8'h00,1, 0,1,8'h00,0,5);
    tbl[21] = V(0,0,1,8'h66,0, 0,1,8'h00,0,5);
    tbl[22] = V(0,1,1,8'h33,1, 1,1,8'h66,1,5);
    tbl[23] = V(0,0,0,8'h00,1, 0,1,8'h00,0,5);
    tbl[24] = V(0,0,1,8'h77,0, 0,1,8'h00,0,5);
    tbl[25] = V(0,0,1,8'h78,0, 1,1,8'h77,1,5);
    tbl[26] = V(1,0,0,8'h00,0, 1,0,8'h77,2,6);
    tbl[27] = V(0,0,1,8'h79,1, 0,1,8'h00,0,0);
    tbl[28] = V(0,0,0,8'h00,1, 1,1,8'h79,1,0);
    tbl[29] = V(0,0,0,8'h00,1, 0,1,8'h00,0,0);
    cyc(1, 0, 0, 8'h00, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 30; k++) begin
      cyc(tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].t, tbl[k].o);
      chk($sformatf("t%0d_valid", k), PW'(ov[0]), PW'(tbl[k].eov));
      chk($sformatf("t%0d_ready", k), PW'(ir[0]), PW'(tbl[k].eir));
      chk($sformatf("t%0d_payload", k), dpl(0), tbl[k].eov ? pl(tbl[k].et) : '0);
      chk($sformatf("t%0d_occ", k), PW'(occ[0]), PW'(tbl[k].eocc));
      chk($sformatf("t%0d_stall", k), PW'(sc0), PW'(tbl[k].est));
    end
    // long stall: MODE0 holds its payload and blocks; 4-bit counter saturates
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h5A, 0);
    for (int k = 1; k <= 21; k++) begin
      cyc(0, 0, k <= 5, 8'hA0 + 8'(k), 0);
      if (k <= 5) begin
        chk($sformatf("s%0d_m0_ready", k), PW'(ir[1]), PW'(0));
        chk($sformatf("s%0d_m0_payload", k), dpl(1), pl(8'h5A));
      end
      if (k == 6) chk("m0_stall5", PW'(sc1), PW'(5));
      if (k == 21) begin
        chk("c4_sat", PW'(sc4), PW'(15));
        chk("m1_stall20", PW'(sc0), PW'(20));
      end
    end
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
          8'($urandom), $urandom_range(0, 3) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
